pw_sched_ctrl: RTL and testbench

//  Sequencer for the pointwise half of the depthwise-separable block. Buffers one pixel's

---
 rtl/pw_sched_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_pw_sched_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pw_sched_ctrl.sv
// pw_sched_ctrl
// Sequencer for the pointwise (1x1) half of a depthwise-separable block.
// Buffers one pixel's depthwise outputs (all input channels), then replays
// them once per output channel into the 1x1 datapath. Each replayed beat carries
// first/last-input-channel flags, a weight address and the output-channel index.
// The sequence repeats for cfg_num_pix pixels, and done then pulses for one cycle.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a job (only honoured in IDLE)
//   cfg_in_ch         input channels per pixel  (latched on start)
//   cfg_out_ch        output channels           (latched on start)
//   cfg_num_pix       pixels in the job         (latched on start)
//   act_in_*          depthwise activation stream (ready only while loading)
//   pw_*              beat stream to the 1x1 conv datapath
//   wt_addr           oc*cfg_in_ch+ic, for a combinational weight read
//   oc_idx            current output channel (bias/requant select)
//   busy              job in progress
//   done              one-cycle pulse at job end
//
// State table
//   state  | meaning
//   IDLE   | waiting for start
//   LOAD   | filling the pixel buffer from act_in
//   RUN    | replaying the buffer, one beat per output/input channel pair
//   SKIP   | zero-sized job accepted; one filler cycle before DONE
//   DONE   | done pulse, then back to IDLE

module pw_sched_ctrl #(
    parameter  int DATA_W  = 8,
    parameter  int MAX_CH  = 1024,
    parameter  int MAX_PIX = 12544,
    localparam int CH_W    = $clog2(MAX_CH + 1),
    localparam int PIX_W   = $clog2(MAX_PIX + 1),
    localparam int WA_W    = $clog2(MAX_CH * MAX_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CH_W-1:0]   cfg_in_ch,
    input  logic [CH_W-1:0]   cfg_out_ch,
    input  logic [PIX_W-1:0]  cfg_num_pix,
    input  logic              act_in_valid,
    output logic              act_in_ready,
    input  logic [DATA_W-1:0] act_in_data,
    output logic              pw_valid,
    input  logic              pw_ready,
    output logic [DATA_W-1:0] pw_data,
    output logic              pw_first_in_ch,
    output logic              pw_last_in_ch,
    output logic [WA_W-1:0]   wt_addr,
    output logic [CH_W-1:0]   oc_idx,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_SKIP = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CH_W-1:0]    cfg_in_q, cfg_in_d;
    logic [CH_W-1:0]    cfg_out_q, cfg_out_d;
    logic [PIX_W-1:0]   cfg_pix_q, cfg_pix_d;
    logic [CH_W-1:0]    ld_cnt_q, ld_cnt_d;
    logic [CH_W-1:0]    ic_q, ic_d;
    logic [CH_W-1:0]    oc_q, oc_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic [WA_W-1:0]    wt_addr_q, wt_addr_d;

    logic [DATA_W-1:0]  buf_q [MAX_CH];
    logic               buf_we;

    logic               last_ic;
    logic               last_oc;
    logic               last_pix;
    logic               cfg_zero;

    assign last_ic  = (ic_q  == cfg_in_q  - CH_W'(1));
    assign last_oc  = (oc_q  == cfg_out_q - CH_W'(1));
    assign last_pix = (pix_q == cfg_pix_q - PIX_W'(1));
    assign cfg_zero = (cfg_in_ch == '0) || (cfg_out_ch == '0) || (cfg_num_pix == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cfg_in_q  <= '0;
            cfg_out_q <= '0;
            cfg_pix_q <= '0;
            ld_cnt_q  <= '0;
            ic_q      <= '0;
            oc_q      <= '0;
            pix_q     <= '0;
            wt_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            cfg_in_q  <= cfg_in_d;
            cfg_out_q <= cfg_out_d;
            cfg_pix_q <= cfg_pix_d;
            ld_cnt_q  <= ld_cnt_d;
            ic_q      <= ic_d;
            oc_q      <= oc_d;
            pix_q     <= pix_d;
            wt_addr_q <= wt_addr_d;
        end
    end

    // Pixel buffer: contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[ld_cnt_q[IDX_W-1:0]] <= act_in_data;
        end
    end

    always_comb begin
        state_d        = state_q;
        cfg_in_d       = cfg_in_q;
        cfg_out_d      = cfg_out_q;
        cfg_pix_d      = cfg_pix_q;
        ld_cnt_d       = ld_cnt_q;
        ic_d           = ic_q;
        oc_d           = oc_q;
        pix_d          = pix_q;
        wt_addr_d      = wt_addr_q;
        buf_we         = 1'b0;
        act_in_ready   = 1'b0;
        pw_valid       = 1'b0;
        pw_data        = '0;
        pw_first_in_ch = 1'b0;
        pw_last_in_ch  = 1'b0;
        wt_addr        = '0;
        oc_idx         = '0;
        done           = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_in_d  = cfg_in_ch;
                    cfg_out_d = cfg_out_ch;
                    cfg_pix_d = cfg_num_pix;
                    ld_cnt_d  = '0;
                    pix_d     = '0;
                    state_d   = cfg_zero ? S_SKIP : S_LOAD;
                end
            end

            S_LOAD: begin
                act_in_ready = 1'b1;
                if (act_in_valid) begin
                    buf_we = 1'b1;
                    if (ld_cnt_q == cfg_in_q - CH_W'(1)) begin
                        ld_cnt_d  = '0;
                        ic_d      = '0;
                        oc_d      = '0;
                        wt_addr_d = '0;
                        state_d   = S_RUN;
                    end else begin
                        ld_cnt_d = ld_cnt_q + CH_W'(1);
                    end
                end
            end

            S_RUN: begin
                pw_valid       = 1'b1;
                pw_data        = buf_q[ic_q[IDX_W-1:0]];
                pw_first_in_ch = (ic_q == '0);
                pw_last_in_ch  = last_ic;
                wt_addr        = wt_addr_q;
                oc_idx         = oc_q;
                if (pw_ready) begin
                    // wt_addr walks oc*in+ic linearly, so a plain increment suffices
                    wt_addr_d = wt_addr_q + WA_W'(1);
                    if (last_ic) begin
                        ic_d = '0;
                        if (last_oc) begin
                            oc_d = '0;
                            if (last_pix) begin
                                pix_d   = '0;
                                state_d = S_DONE;
                            end else begin
                                pix_d    = pix_q + PIX_W'(1);
                                ld_cnt_d = '0;
                                state_d  = S_LOAD;
                            end
                        end else begin
                            oc_d = oc_q + CH_W'(1);
                        end
                    end else begin
                        ic_d = ic_q + CH_W'(1);
                    end
                end
            end

            S_SKIP: begin
                state_d = S_DONE;
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_pw_sched_ctrl.sv
module tb_pw_sched_ctrl;

    localparam int DATA_W = 8;
    localparam int CH_W   = 11;
    localparam int PIX_W  = 14;
    localparam int WA_W   = 20;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [CH_W-1:0]   cfg_in_ch;
    logic [CH_W-1:0]   cfg_out_ch;
    logic [PIX_W-1:0]  cfg_num_pix;
    logic              act_in_valid;
    logic              act_in_ready;
    logic [DATA_W-1:0] act_in_data;
    logic              pw_valid;
    logic              pw_ready;
    logic [DATA_W-1:0] pw_data;
    logic              pw_first_in_ch;
    logic              pw_last_in_ch;
    logic [WA_W-1:0]   wt_addr;
    logic [CH_W-1:0]   oc_idx;
    logic              busy;
    logic              done;

    pw_sched_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .cfg_in_ch      (cfg_in_ch),
        .cfg_out_ch     (cfg_out_ch),
        .cfg_num_pix    (cfg_num_pix),
        .act_in_valid   (act_in_valid),
        .act_in_ready   (act_in_ready),
        .act_in_data    (act_in_data),
        .pw_valid       (pw_valid),
        .pw_ready       (pw_ready),
        .pw_data        (pw_data),
        .pw_first_in_ch (pw_first_in_ch),
        .pw_last_in_ch  (pw_last_in_ch),
        .wt_addr        (wt_addr),
        .oc_idx         (oc_idx),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // beat = {data, first, last, wt_addr, oc_idx}
    logic [40:0]      exp_q[$];
    logic [7:0]       act_q[$];
    logic [7:0]       acts_g[$];
    int               n_tests = 0;
    int               n_fail  = 0;
    int               beats_left = 0;
    int               beat_no = 0;
    int               done_cnt = 0;
    int               job_in_ch = 1;
    int               ld_seen = 0;
    int               rdy_mode = 0;
    bit               act_rand = 0;
    bit               expect_done = 0;
    bit               zero_job = 0;
    bit               pv_check = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [40:0] cur_beat();
        return {pw_data, pw_first_in_ch, pw_last_in_ch, wt_addr, oc_idx};
    endfunction

    // pw_ready driver: 0 = always ready, 1 = repeating 1-0-0-1, 2 = random
    initial begin
        int ph;
        ph = 0;
        pw_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       pw_ready = (ph == 0) || (ph == 3);
                2:       pw_ready = ($urandom_range(0, 2) != 0);
                default: pw_ready = 1'b1;
            endcase
            ph = (ph + 1) % 4;
        end
    end

    // Activation source; also checks the load -> first pw_valid latency
    initial begin
        act_in_valid = 1'b0;
        act_in_data  = '0;
        forever begin
            @(negedge clk);
            if (pv_check) begin
                chk("load_to_pw_valid", 64'(pw_valid), 64'd1);
                pv_check = 0;
            end
            if (rst_n && act_in_valid && act_in_ready) begin
                void'(act_q.pop_front());
                ld_seen++;
                if (ld_seen % job_in_ch == 0) pv_check = 1;
            end
            @(posedge clk);
            #1;
            if (act_q.size() > 0 && (!act_rand || $urandom_range(0, 2) != 0)) begin
                act_in_valid = 1'b1;
                act_in_data  = act_q[0];
            end else begin
                act_in_valid = 1'b0;
                act_in_data  = 8'($urandom);
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic        held_v;
        logic [40:0] held;
        logic [40:0] e;
        held_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_v = 1'b0;
            end else begin
                if (expect_done) begin
                    chk("done_after_last_beat", 64'(done), 64'd1);
                    expect_done = 0;
                end else if (done && !zero_job) begin
                    chk("spurious_done", 64'(done), 64'd0);
                end
                if (done) done_cnt++;
                if (held_v) begin
                    chk("stall_valid_held", 64'(pw_valid), 64'd1);
                    chk("stall_beat_held", 64'(cur_beat()), 64'(held));
                end
                if (pw_valid) begin
                    chk("no_load_during_run", 64'(act_in_ready), 64'd0);
                end else begin
                    chk("outputs_zero_when_idle", 64'(cur_beat()), 64'd0);
                end
                if (pw_valid && pw_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", 64'(cur_beat()), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("beat%0d", beat_no), 64'(cur_beat()), 64'(e));
                        beat_no++;
                        beats_left--;
                        if (beats_left == 0) expect_done = 1;
                    end
                end
                held_v = pw_valid && !pw_ready;
                held   = cur_beat();
            end
        end
    end

    // Reference model: expected beat list from the job description
    task automatic load_job(input int in_ch, input int out_ch, input int npix);
        for (int p = 0; p < npix; p++)
            for (int oc = 0; oc < out_ch; oc++)
                for (int ic = 0; ic < in_ch; ic++)
                    exp_q.push_back({acts_g[p*in_ch+ic], 1'(ic == 0), 1'(ic == in_ch-1),
                                     WA_W'(oc*in_ch+ic), CH_W'(oc)});
        foreach (acts_g[i]) act_q.push_back(acts_g[i]);
        beats_left = in_ch * out_ch * npix;
        job_in_ch  = in_ch;
        ld_seen    = 0;
        beat_no    = 0;
    endtask

    task automatic pulse_start(input int in_ch, input int out_ch, input int npix);
        @(posedge clk);
        #1;
        cfg_in_ch   = CH_W'(in_ch);
        cfg_out_ch  = CH_W'(out_ch);
        cfg_num_pix = PIX_W'(npix);
        start       = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        // latched copies must be used from here on
        cfg_in_ch   = CH_W'($urandom_range(0, 7));
        cfg_out_ch  = CH_W'($urandom_range(0, 7));
        cfg_num_pix = PIX_W'($urandom_range(0, 3));
    endtask

    task automatic run_job(input int in_ch, input int out_ch, input int npix);
        int d0;
        bit ok;
        load_job(in_ch, out_ch, npix);
        d0 = done_cnt;
        pulse_start(in_ch, out_ch, npix);
        @(negedge clk);
        chk("start_to_ready", 64'(act_in_ready), 64'd1);
        ok = 0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            if (done_cnt != d0) begin
                ok = 1;
                break;
            end
            #1;
            start = (k == 4) && busy;  // must be ignored while busy
        end
        start = 1'b0;
        chk("job_completes", 64'(ok), 64'd1);
        repeat (2) @(posedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("single_done", 64'(done_cnt - d0), 64'd1);
        exp_q.delete();
        act_q.delete();
    endtask

    initial begin
        int in_ch, out_ch, npix;
        bit ok;
        rst_n       = 1'b0;
        start       = 1'b0;
        cfg_in_ch   = '0;
        cfg_out_ch  = '0;
        cfg_num_pix = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_outputs", 64'({pw_valid, act_in_ready, done, cur_beat()}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // case 1
        acts_g = '{8'd10, 8'd20, 8'd30};
        rdy_mode = 0; act_rand = 0;
        run_job(3, 2, 1);

        // case 2: stalls
        rdy_mode = 1;
        run_job(3, 2, 1);

        // case 3: two pixels
        rdy_mode = 0;
        acts_g = '{8'd1, 8'd2, 8'd3, 8'd4};
        run_job(2, 2, 2);

        // case 4: single input channel
        acts_g = '{8'hFB};
        run_job(1, 4, 1);

        // case 5: zero-sized job
        zero_job = 1;
        pulse_start(3, 0, 1);
        @(negedge clk);
        chk("zero_busy_c1", 64'({busy, done, act_in_ready, pw_valid}), 64'b1000);
        @(negedge clk);
        chk("zero_busy_c2", 64'({busy, done, act_in_ready, pw_valid}), 64'b1100);
        @(negedge clk);
        chk("zero_idle_c3", 64'({busy, done, act_in_ready, pw_valid}), 64'b0000);
        zero_job = 0;

        // case 6: reset mid-RUN, then identical rerun
        acts_g = '{8'd10, 8'd20, 8'd30};
        load_job(3, 2, 1);
        pulse_start(3, 2, 1);
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            if (beats_left <= 3) begin
                ok = 1;
                break;
            end
        end
        chk("reached_mid_run", 64'(ok), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_busy", 64'(busy), 64'd0);
        chk("async_reset_outputs", 64'({pw_valid, act_in_ready, done, cur_beat()}), 64'd0);
        exp_q.delete();
        act_q.delete();
        beats_left  = 0;
        expect_done = 0;
        pv_check    = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_job(3, 2, 1);

        // randomized jobs
        rdy_mode = 2; act_rand = 1;
        for (int j = 0; j < 12; j++) begin
            in_ch  = $urandom_range(1, 6);
            out_ch = $urandom_range(1, 4);
            npix   = $urandom_range(1, 3);
            acts_g.delete();
            for (int i = 0; i < in_ch * npix; i++) acts_g.push_back(8'($urandom));
            run_job(in_ch, out_ch, npix);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
